// File: rtl/raptor64_logic_arbiter_pkg.sv
// Shared constants for the Raptor64 logical-op arbiter slice: opcode/func
// values of the logical instruction group and the request bundle type.
package raptor64_logic_arbiter_pkg;

  localparam int IR_W = 42;
  localparam int DW   = 64;

  // Major opcodes (ir[41:35])
  localparam logic [6:0] OP_RR   = 7'h02;
  localparam logic [6:0] OP_ANDI = 7'h0C;
  localparam logic [6:0] OP_ORI  = 7'h0D;
  localparam logic [6:0] OP_XORI = 7'h0E;

  // RR function codes (ir[6:0])
  localparam logic [6:0] F_AND  = 7'h00;
  localparam logic [6:0] F_OR   = 7'h01;
  localparam logic [6:0] F_XOR  = 7'h02;
  localparam logic [6:0] F_ANDC = 7'h03;
  localparam logic [6:0] F_NAND = 7'h04;
  localparam logic [6:0] F_NOR  = 7'h05;
  localparam logic [6:0] F_XNOR = 7'h06;
  localparam logic [6:0] F_ORC  = 7'h07;

  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic [DW-1:0]   imm;
  } logicReq_t;

  function automatic logic [6:0] irOpcode(input logic [IR_W-1:0] ir);
    return ir[41:35];
  endfunction

  function automatic logic [6:0] irFunc(input logic [IR_W-1:0] ir);
    return ir[6:0];
  endfunction

endpackage

// File: rtl/raptor64_logic_arbiter_if.sv
// Request/result bundle between issue logic, the arbiter and the consumer.
interface raptor64_logic_arbiter_if #(parameter int CNT_W = 32);
  logic [1:0]       req_v_i;
  logic [1:0]       req_rdy_o;
  logic [41:0]      ir0_i, ir1_i;
  logic [63:0]      a0_i, a1_i;
  logic [63:0]      b0_i, b1_i;
  logic [63:0]      imm0_i, imm1_i;
  logic             res_v_o;
  logic             res_rdy_i;
  logic [63:0]      res_o;
  logic             res_id_o;
  logic             res_ill_o;
  logic [CNT_W-1:0] op_cnt_o;

  // Arbiter side
  modport slave (
    input  req_v_i, ir0_i, ir1_i, a0_i, a1_i, b0_i, b1_i, imm0_i, imm1_i, res_rdy_i,
    output req_rdy_o, res_v_o, res_o, res_id_o, res_ill_o, op_cnt_o
  );

  // Requester/consumer side
  modport master (
    output req_v_i, ir0_i, ir1_i, a0_i, a1_i, b0_i, b1_i, imm0_i, imm1_i, res_rdy_i,
    input  req_rdy_o, res_v_o, res_o, res_id_o, res_ill_o, op_cnt_o
  );
endinterface

// File: rtl/raptor64_logic_core.sv
// Combinational logical-op unit: decodes RR func or immediate opcode and
// produces the result, flagging anything outside the logical group.
module raptor64_logic_core
  import raptor64_logic_arbiter_pkg::*;
(
  input  logic [IR_W-1:0] ir,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  input  logic [DW-1:0]   imm,
  output logic [DW-1:0]   res,
  output logic            ill
);
  // Middle instruction bits carry register fields not needed here.
  logic unusedIr;
  assign unusedIr = ^ir[34:7];

  // Decode and compute; unknown encodings give zero with the illegal flag.
  always_comb begin
    res = '0;
    ill = 1'b0;
    case (irOpcode(ir))
      OP_RR: begin
        case (irFunc(ir))
          F_AND:   res = a & b;
          F_OR:    res = a | b;
          F_XOR:   res = a ^ b;
          F_ANDC:  res = a & ~b;
          F_NAND:  res = ~(a & b);
          F_NOR:   res = ~(a | b);
          F_XNOR:  res = ~(a ^ b);
          F_ORC:   res = a | ~b;
          default: ill = 1'b1;
        endcase
      end
      OP_ANDI: res = a & imm;
      OP_ORI:  res = a | imm;
      OP_XORI: res = a ^ imm;
      default: ill = 1'b1;
    endcase
  end
endmodule

// File: rtl/raptor64_logic_arbiter.sv
// Two-requester arbiter in front of the logical-op unit with a one-entry
// registered result stage and a wrapping completed-op counter.
module raptor64_logic_arbiter
  import raptor64_logic_arbiter_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter bit FAIR  = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  raptor64_logic_arbiter_if.slave bus
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state, stateNxt;
  logic [1:0]       gnt;
  logic             canAccept, accept, lastGnt;
  logicReq_t        req0, req1, sel;
  logic [DW-1:0]    coreRes, resQ;
  logic             coreIll, illQ, idQ;
  logic [CNT_W-1:0] cnt;

  assign req0 = '{ir: bus.ir0_i, a: bus.a0_i, b: bus.b0_i, imm: bus.imm0_i};
  assign req1 = '{ir: bus.ir1_i, a: bus.a1_i, b: bus.b1_i, imm: bus.imm1_i};

  // A held result can be replaced in the same cycle it drains.
  assign canAccept = (state == EMPTY) || bus.res_rdy_i;

  // Grant: one-hot winner; on a tie the requester not served last wins (FAIR).
  always_comb begin
    gnt = 2'b00;
    if (canAccept && !rst_i) begin
      case (bus.req_v_i)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (FAIR && !lastGnt) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign accept = gnt[0] & bus.req_v_i[0] | gnt[1] & bus.req_v_i[1];
  assign sel    = gnt[1] ? req1 : req0;

  raptor64_logic_core uCore (
    .ir  (sel.ir),
    .a   (sel.a),
    .b   (sel.b),
    .imm (sel.imm),
    .res (coreRes),
    .ill (coreIll)
  );

  // Output-stage state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= EMPTY;
    else       state <= stateNxt;
  end

  // Next state: fill on accept, drain only when consumed with nothing new
  always_comb begin
    stateNxt = state;
    case (state)
      EMPTY: if (accept) stateNxt = FULL;
      FULL:  if (bus.res_rdy_i && !accept) stateNxt = EMPTY;
      default: stateNxt = EMPTY;
    endcase
  end

  // Result register and arbitration pointer, both move only on accept
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resQ    <= '0;
      idQ     <= 1'b0;
      illQ    <= 1'b0;
      lastGnt <= 1'b1;
    end else if (accept) begin
      resQ    <= coreRes;
      idQ     <= gnt[1];
      illQ    <= coreIll;
      lastGnt <= gnt[1];
    end
  end

  // Completed-op counter, wraps naturally
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                  cnt <= '0;
    else if (state == FULL && bus.res_rdy_i)    cnt <= cnt + 1'b1;
  end

  assign bus.req_rdy_o = gnt;
  assign bus.res_v_o   = (state == FULL);
  assign bus.res_o     = resQ;
  assign bus.res_id_o  = idQ;
  assign bus.res_ill_o = illQ;
  assign bus.op_cnt_o  = cnt;
endmodule

// File: tb/tb_raptor64_logic_arbiter.sv
// Bench: two DUTs (FAIR=1/CNT_W=4 and FAIR=0/CNT_W=32) share one stimulus;
// a transaction-level model predicts both every cycle, and directed
// literal checks pin the model.
module tb_raptor64_logic_arbiter;
  import raptor64_logic_arbiter_pkg::*;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  reqV = '0;
  logic [41:0] ir0 = '0, ir1 = '0;
  logic [63:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0, imm0 = '0, imm1 = '0;
  logic        resRdy = 1'b0;

  raptor64_logic_arbiter_if #(.CNT_W(4))  ifA ();
  raptor64_logic_arbiter_if #(.CNT_W(32)) ifB ();

  assign ifA.req_v_i = reqV;  assign ifB.req_v_i = reqV;
  assign ifA.ir0_i = ir0;     assign ifB.ir0_i = ir0;
  assign ifA.ir1_i = ir1;     assign ifB.ir1_i = ir1;
  assign ifA.a0_i = a0;       assign ifB.a0_i = a0;
  assign ifA.a1_i = a1;       assign ifB.a1_i = a1;
  assign ifA.b0_i = b0;       assign ifB.b0_i = b0;
  assign ifA.b1_i = b1;       assign ifB.b1_i = b1;
  assign ifA.imm0_i = imm0;   assign ifB.imm0_i = imm0;
  assign ifA.imm1_i = imm1;   assign ifB.imm1_i = imm1;
  assign ifA.res_rdy_i = resRdy; assign ifB.res_rdy_i = resRdy;

  raptor64_logic_arbiter #(.CNT_W(4),  .FAIR(1'b1)) dutA (.clk_i(clk), .rst_i(rst), .bus(ifA));
  raptor64_logic_arbiter #(.CNT_W(32), .FAIR(1'b0)) dutB (.clk_i(clk), .rst_i(rst), .bus(ifB));

  // Observed outputs, indexed by DUT
  logic [1:0]  oRdy[2];
  logic        oV[2], oId[2], oIll[2];
  logic [63:0] oRes[2];
  logic [31:0] oCnt[2];
  assign oRdy[0] = ifA.req_rdy_o; assign oRdy[1] = ifB.req_rdy_o;
  assign oV[0]   = ifA.res_v_o;   assign oV[1]   = ifB.res_v_o;
  assign oRes[0] = ifA.res_o;     assign oRes[1] = ifB.res_o;
  assign oId[0]  = ifA.res_id_o;  assign oId[1]  = ifB.res_id_o;
  assign oIll[0] = ifA.res_ill_o; assign oIll[1] = ifB.res_ill_o;
  assign oCnt[0] = {28'd0, ifA.op_cnt_o};
  assign oCnt[1] = ifB.op_cnt_o;

  int tests = 0, fails = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------- model ----------------
  bit          mFull[2], mId[2], mIll[2], mLast[2];
  logic [63:0] mRes[2];
  int unsigned mCnt[2];
  localparam bit MFAIR[2] = '{1'b1, 1'b0};
  localparam int unsigned MMOD[2] = '{16, 0};  // 0 = full 32-bit wrap

  function automatic logic [64:0] expOp(input logic [41:0] ir, input logic [63:0] a, b, imm);
    logic [6:0] op = ir[41:35], fn = ir[6:0];
    if (op == OP_RR) begin
      if (fn == F_AND)  return {1'b0, a & b};
      if (fn == F_OR)   return {1'b0, a | b};
      if (fn == F_XOR)  return {1'b0, a ^ b};
      if (fn == F_ANDC) return {1'b0, a & ~b};
      if (fn == F_NAND) return {1'b0, ~(a & b)};
      if (fn == F_NOR)  return {1'b0, ~(a | b)};
      if (fn == F_XNOR) return {1'b0, ~(a ^ b)};
      if (fn == F_ORC)  return {1'b0, a | ~b};
      return {1'b1, 64'd0};
    end
    if (op == OP_ANDI) return {1'b0, a & imm};
    if (op == OP_ORI)  return {1'b0, a | imm};
    if (op == OP_XORI) return {1'b0, a ^ imm};
    return {1'b1, 64'd0};
  endfunction

  // Which requester is served this cycle (-1 = none)
  function automatic int winner(input int k);
    if (rst || (mFull[k] && !resRdy)) return -1;
    if (reqV == 2'b01) return 0;
    if (reqV == 2'b10) return 1;
    if (reqV == 2'b11) return (MFAIR[k] && mLast[k] == 1'b0) ? 1 : 0;
    return -1;
  endfunction

  function automatic logic [31:0] cntView(input int k);
    return (MMOD[k] != 0) ? 32'(mCnt[k] % MMOD[k]) : 32'(mCnt[k]);
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mFull[k] = 0; mRes[k] = '0; mId[k] = 0; mIll[k] = 0; mCnt[k] = 0; mLast[k] = 1;
      end else begin
        int w;
        logic [64:0] r;
        w = winner(k);
        if (mFull[k] && resRdy) mCnt[k]++;
        if (w >= 0) begin
          r = (w == 0) ? expOp(ir0, a0, b0, imm0) : expOp(ir1, a1, b1, imm1);
          mRes[k] = r[63:0]; mIll[k] = r[64]; mId[k] = (w == 1);
          mFull[k] = 1; mLast[k] = (w == 1);
        end else if (mFull[k] && resRdy) begin
          mFull[k] = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int w;
      w = winner(k);
      check($sformatf("d%0d.req_rdy", k), 64'(oRdy[k]), (w < 0) ? 64'd0 : 64'(2'b01 << w));
      check($sformatf("d%0d.res_v", k), 64'(oV[k]), 64'(mFull[k]));
      check($sformatf("d%0d.res", k), oRes[k], mRes[k]);
      check($sformatf("d%0d.res_id", k), 64'(oId[k]), 64'(mId[k]));
      check($sformatf("d%0d.res_ill", k), 64'(oIll[k]), 64'(mIll[k]));
      check($sformatf("d%0d.op_cnt", k), 64'(oCnt[k]), 64'(cntView(k)));
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [41:0] mkIr(input logic [6:0] op, input logic [6:0] fn);
    return {op, 28'd0, fn};
  endfunction

  task automatic nextCyc();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  gA[4], gB[4];
    logic [63:0] held;
    logic [1:0]  g01, g10;
    g01 = 2'b01; g10 = 2'b10;

    // Reset: grant suppressed even with a pending request
    reqV = 2'b01; ir0 = mkIr(OP_RR, F_AND);
    @(negedge clk);
    check("rst.req_rdy", 64'(ifA.req_rdy_o), 64'd0);
    check("rst.res_v", 64'(ifA.res_v_o), 64'd0);
    reqV = 2'b00;
    @(posedge clk); #1 rst = 1'b0;

    // req0 RR/AND
    ir0 = mkIr(OP_RR, F_AND); a0 = 64'hF0F0; b0 = 64'hFF00; resRdy = 1'b1; reqV = 2'b01;
    @(negedge clk);
    check("and.gnt", 64'(ifA.req_rdy_o), 64'(g01));
    nextCyc(); reqV = 2'b00;
    @(negedge clk);
    check("and.res", ifA.res_o, 64'hF000);
    check("and.id", 64'(ifA.res_id_o), 64'd0);
    check("and.ill", 64'(ifA.res_ill_o), 64'd0);
    nextCyc();
    check("and.cnt", 64'(ifA.op_cnt_o), 64'd1);

    // Both requesters every cycle, XORI
    ir0 = mkIr(OP_XORI, 7'd0); a0 = 64'hFF; imm0 = 64'h0F;
    ir1 = mkIr(OP_XORI, 7'd0); a1 = 64'hFF; imm1 = 64'h0F;
    reqV = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      gA[i] = ifA.req_rdy_o; gB[i] = ifB.req_rdy_o;
      nextCyc();
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr.gntA%0d", i), 64'(gA[i]), (i % 2 == 0) ? 64'(g10) : 64'(g01));
      check($sformatf("fix.gntB%0d", i), 64'(gB[i]), 64'(g01));
    end
    @(negedge clk);
    check("xori.res", ifA.res_o, 64'hF0);

    // Backpressure with req1 pending
    nextCyc();
    resRdy = 1'b0; reqV = 2'b10;
    ir1 = mkIr(OP_RR, F_OR); a1 = 64'h0F; b1 = 64'hF0;
    held = ifA.res_o;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp.rdy%0d", i), 64'(ifA.req_rdy_o), 64'd0);
      check($sformatf("bp.res%0d", i), ifA.res_o, held);
      nextCyc();
    end
    resRdy = 1'b1;
    @(negedge clk);
    check("bp.release", 64'(ifA.req_rdy_o), 64'(g10));
    nextCyc(); reqV = 2'b00;
    @(negedge clk);
    check("bp.res", ifA.res_o, 64'hFF);
    check("bp.id", 64'(ifA.res_id_o), 64'd1);

    // Illegal opcode, then RR with unknown func
    nextCyc();
    ir0 = mkIr(7'h7F, F_AND); a0 = 64'hFFFF; b0 = 64'hFFFF; reqV = 2'b01;
    nextCyc();
    ir0 = mkIr(OP_RR, 7'h30);
    @(negedge clk);
    check("ill.op.res", ifA.res_o, 64'd0);
    check("ill.op.flag", 64'(ifA.res_ill_o), 64'd1);
    nextCyc(); reqV = 2'b00;
    @(negedge clk);
    check("ill.fn.res", ifA.res_o, 64'd0);
    check("ill.fn.flag", 64'(ifA.res_ill_o), 64'd1);

    // Async reset while a result is held
    nextCyc();
    resRdy = 1'b0; reqV = 2'b01; ir0 = mkIr(OP_RR, F_AND);
    nextCyc(); nextCyc();
    #2 rst = 1'b1;
    #1;
    check("arst.res_v", 64'(ifA.res_v_o), 64'd0);
    check("arst.cnt", 64'(ifB.op_cnt_o), 64'd0);
    check("arst.rdy", 64'(ifA.req_rdy_o), 64'd0);
    reqV = 2'b00;
    @(posedge clk); #1 rst = 1'b0;

    // Counter wrap: 16 back-to-back RR/NOR ops
    resRdy = 1'b1; reqV = 2'b01; ir0 = mkIr(OP_RR, F_NOR); a0 = '0; b0 = '0;
    for (int i = 0; i < 16; i++) nextCyc();
    reqV = 2'b00;
    nextCyc();
    check("wrap.cntA", 64'(ifA.op_cnt_o), 64'd0);
    check("wrap.cntB", 64'(ifB.op_cnt_o), 64'd16);
    check("wrap.res_v", 64'(ifA.res_v_o), 64'd0);
    check("nor.res", ifA.res_o, 64'hFFFF_FFFF_FFFF_FFFF);

    nextCyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
